// File: rtl/irq_latch.sv
`default_nettype none
// ============================================================================
//  Module   : irq_latch
//  Purpose  : Interrupt capture and presentation stage feeding the 8-to-3
//             priority encoder. Raw request lines are latched into a pending
//             register. The highest-priority pending line that is also enabled
//             by the mask is presented as a frozen 3-bit id with a valid/ack
//             handshake. On ack the presented pending bit is cleared.
//
//  Ports    : clk        in   clock, rising edge
//             rst        in   synchronous active-high reset
//             req[7:0]   in   raw request lines, bit 7 = highest priority
//             mask[7:0]  in   per-line presentation enable (1 = enabled)
//             ack        in   consumer acknowledge of the presented id
//             irq_valid  out  a request is being presented
//             irq_id     out  index of presented request (valid w/ irq_valid)
//             pending    out  registered pending vector (unmasked)
//
//  Config   : IRQ_EDGE_DETECT_EN defined   -> rising-edge capture of req
//             IRQ_EDGE_DETECT_EN undefined -> level capture of req
//
//  Revision : 1.0  initial release
// ============================================================================
module irq_latch #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic           ack,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    output logic [N-1:0]   pending
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]     r_state;
    logic [N-1:0]   r_pending;
    logic [IDW-1:0] r_irq_id;
    logic           r_irq_valid;

    logic [N-1:0]   w_set;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_active;
    logic [IDW-1:0] w_sel;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0]   r_req_d;

    // Rising-edge capture. r_req_d resets to 0, so a line held high through
    // reset produces one event on the first edge after release.
    assign w_set = req & ~r_req_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d <= '0;
        end else begin
            r_req_d <= req;
        end
    end
`else
    // Level capture: a held line re-arms its pending bit every cycle.
    assign w_set = req;
`endif

    // Clear only the presented line, and only when the ack is actually taken.
    always_comb begin
        w_clr = '0;
        if (r_state == c_BUSY && ack) begin
            w_clr[r_irq_id] = 1'b1;
        end
    end

    assign w_active = r_pending & mask;

    // Highest set bit wins: later (higher) indices overwrite lower ones.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (w_active[i]) begin
                w_sel = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_irq_id    <= '0;
            r_irq_valid <= 1'b0;
            r_state     <= c_IDLE;
        end else begin
            // Set is OR-ed after the clear so a coincident new event survives.
            r_pending <= (r_pending & ~w_clr) | w_set;
            case (r_state)
                c_IDLE: begin
                    if (|w_active) begin
                        r_irq_id    <= w_sel;
                        r_irq_valid <= 1'b1;
                        r_state     <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    // id/valid frozen until ack, regardless of mask/pending.
                    if (ack) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign irq_valid = r_irq_valid;
    assign irq_id    = r_irq_id;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_latch
//  Purpose  : Self-checking bench for irq_latch. Expected presentation ids
//             are queued as stimulus is applied and popped whenever the DUT
//             has a presentation acknowledged; cycle-level expectations for
//             valid/id/pending are checked directly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_latch;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;

    int n_total = 0;
    int n_bad   = 0;
    logic [2:0] r_exp_q[$];

    irq_latch #(.N(8), .IDW(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .ack       (ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every acknowledged presentation must match the next queued id.
    always @(negedge clk) begin
        if (!rst && irq_valid === 1'b1 && ack === 1'b1) begin
            if (r_exp_q.size() == 0) begin
                chk("sb_unexpected", {29'd0, irq_id}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_id", {29'd0, irq_id}, {29'd0, r_exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; req = 8'hFF; mask = 8'hFF; ack = 1'b0;

        // ---------------- reset ----------------
        tick(); tick(); tick();
        chk("rst_valid",   irq_valid, 0);
        chk("rst_id",      irq_id,    0);
        chk("rst_pending", pending,   0);
        rst = 1'b0;
        tick();
        chk("rel_pending", pending, 8'hFF);
        chk("rel_valid0",  irq_valid, 0);
        tick();
        chk("rel_valid1",  irq_valid, 1);
        chk("rel_id7",     irq_id,    7);
        // drain all eight lines, highest first
        req = 8'h00; ack = 1'b1;
        for (int i = 7; i >= 0; i--) r_exp_q.push_back(3'(i));
        for (int i = 0; i < 16; i++) tick();
        chk("drain_pending", pending, 0);
        chk("drain_valid",   irq_valid, 0);

        // ---------------- priority drain ----------------
        req = 8'b0010_0100; ack = 1'b1;
        r_exp_q.push_back(3'd5); r_exp_q.push_back(3'd2);
        tick();
        req = 8'h00;
        chk("pri_pending", pending, 8'h24);
        tick();
        chk("pri_v5", irq_valid, 1); chk("pri_id5", irq_id, 5);
        tick();
        chk("pri_gap", irq_valid, 0); chk("pri_pend2", pending, 8'h04);
        tick();
        chk("pri_v2", irq_valid, 1); chk("pri_id2", irq_id, 2);
        tick();
        chk("pri_end_v", irq_valid, 0); chk("pri_end_p", pending, 0);

        // ---------------- masking ----------------
        ack = 1'b0; mask = 8'hBF; req = 8'h40;
        tick();
        req = 8'h00;
        chk("msk_pending", pending, 8'h40);
        tick(); tick(); tick();
        chk("msk_novalid", irq_valid, 0);
        chk("msk_pend_hold", pending, 8'h40);
        mask = 8'hFF;
        r_exp_q.push_back(3'd6);
        tick();
        chk("msk_v", irq_valid, 1); chk("msk_id6", irq_id, 6);
        ack = 1'b1;
        tick();
        chk("msk_clr_v", irq_valid, 0); chk("msk_clr_p", pending, 0);
        ack = 1'b0;

        // ---------------- hold under change ----------------
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        chk("hold_v", irq_valid, 1); chk("hold_id3", irq_id, 3);
        req = 8'h80; mask = 8'hF7;
        tick();
        req = 8'h00;
        chk("hold_pend", pending, 8'h88);
        chk("hold_id_a", irq_id, 3);
        tick(); tick();
        chk("hold_v_b", irq_valid, 1); chk("hold_id_b", irq_id, 3);
        r_exp_q.push_back(3'd3); r_exp_q.push_back(3'd7);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("hold_ack_v", irq_valid, 0); chk("hold_ack_p", pending, 8'h80);
        tick();
        chk("hold_next_v", irq_valid, 1); chk("hold_next_id7", irq_id, 7);
        ack = 1'b1;
        tick();
        ack = 1'b0; mask = 8'hFF;
        chk("hold_done_p", pending, 0);

        // ---------------- set/clear collision ----------------
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        chk("col_v", irq_valid, 1); chk("col_id4", irq_id, 4);
        r_exp_q.push_back(3'd4); r_exp_q.push_back(3'd4);
        ack = 1'b1; req = 8'h10;
        tick();
        ack = 1'b0; req = 8'h00;
        chk("col_keep", pending, 8'h10); chk("col_gap", irq_valid, 0);
        tick();
        chk("col_again_v", irq_valid, 1); chk("col_again_id", irq_id, 4);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("col_end_p", pending, 0);

        // ---------------- held line ----------------
        req = 8'h01; ack = 1'b1;
        tick();
        chk("held_pend", pending, 8'h01);
`ifdef IRQ_EDGE_DETECT_EN
        r_exp_q.push_back(3'd0);
        tick();
        chk("edge_v", irq_valid, 1); chk("edge_id0", irq_id, 0);
        tick();
        chk("edge_clr_v", irq_valid, 0); chk("edge_clr_p", pending, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("edge_once_v", irq_valid, 0);
            chk("edge_once_p", pending, 0);
        end
        req = 8'h00;
`else
        for (int k = 0; k < 3; k++) begin
            r_exp_q.push_back(3'd0);
            tick();
            chk("lvl_v1", irq_valid, 1); chk("lvl_id0", irq_id, 0);
            if (k == 2) req = 8'h00;
            tick();
            chk("lvl_v0", irq_valid, 0);
        end
        chk("lvl_end_p", pending, 0);
        tick(); tick();
        chk("lvl_stay_v", irq_valid, 0);
`endif
        ack = 1'b0;

        // ---------------- reset overrides in-flight BUSY/ack ----------------
        req = 8'h02;
        tick();
        req = 8'h00;
        tick();
        chk("ovr_v", irq_valid, 1); chk("ovr_id1", irq_id, 1);
        rst = 1'b1; ack = 1'b1;
        tick();
        chk("ovr_rst_v", irq_valid, 0); chk("ovr_rst_id", irq_id, 0);
        chk("ovr_rst_p", pending, 0);
        rst = 1'b0; ack = 1'b0;
        tick(); tick();
        chk("ovr_quiet", irq_valid, 0);

        chk("sb_empty", r_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_latch.md
# irq_latch

Interrupt capture and presentation stage that sits directly upstream of the 8-to-3 priority encoder. It latches eight raw request lines into a pending register and gates them with a per-line enable mask. It presents the highest-priority pending request as a stable 3-bit identifier with a valid/ack handshake. The identifier is held frozen until acknowledged, then the corresponding pending bit is cleared.

## Interface
- `N`, 8, number of request lines (fixed at 8 for this block)
- `IDW`, 3, identifier width, equal to log2(`N`)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  8  raw request lines; bit 7 has the highest priority
- `mask`  in  8  per-line enable (1 = line may be presented)
- `ack`  in  1  consumer acknowledges the presented request
- `irq_valid`  out  1  a request is being presented
- `irq_id`  out  3  index of the presented request; valid only while `irq_valid`=1
- `pending`  out  8  registered pending vector (unmasked), for status readback

## Operation
- Registers: `req_d[7:0]`, `pending[7:0]`, `state` (IDLE/BUSY), `irq_id`, `irq_valid`.
- Capture: `set[i]` = edge or level event on `req[i]` (see Configuration). Every cycle, `pending <= (pending & ~clr) | set`. Capture ignores `mask`; masked events stay pending.
- `clr` is one-hot at `irq_id` when `state`=BUSY and `ack`=1; otherwise 0.
- When `set` and `clr` hit the same bit in the same cycle, set wins: the bit stays 1 and the new event is not lost.
- IDLE: if `pending & mask` is nonzero, `irq_id` <= index of the highest set bit of `pending & mask`, `irq_valid` <= 1, and the state goes to BUSY. Otherwise the block stays in IDLE.
- BUSY: `irq_id` and `irq_valid` are held. Changes on `mask` or `pending` do not retract or re-select the presented request.
  - On `ack`=1: the pending bit is cleared, `irq_valid` <= 0, and the state goes to IDLE.
- `ack` is ignored in IDLE.
- The block never presents a request that is not pending at the selection edge.

## Timing
- Reset, synchronous on `rst`=1 at a clock edge: `pending`=0, `req_d`=0, `irq_valid`=0, `irq_id`=0, state IDLE. `rst` overrides all other activity, including an in-flight BUSY/ack.
- Because `req_d` resets to 0, a line held high through reset is captured once, on the first edge after `rst` deasserts. This applies in edge mode.
- Latency:
  - A `req` rising edge sampled at clock edge E sets `pending` after E.
  - `irq_valid` rises after E+1, if the block is in IDLE and the line is unmasked.
- Handshake:
  - `ack` is sampled only while `irq_valid`=1.
  - `irq_valid` falls one edge after the sampled ack.
  - There is a minimum of one IDLE cycle with `irq_valid`=0 between consecutive presentations.
  - Back-to-back throughput is one request per 2 cycles when `ack` is tied high.
- A request masked at its selection edge waits in `pending`. It is presented one edge after `mask` enables it, if the block is in IDLE.

## Configuration
- `IRQ_EDGE_DETECT_EN` defined: `set = req & ~req_d` (rising-edge capture, `req_d <= req` each cycle). A line held high produces exactly one event.
- Not defined: `set = req` (level capture). `req_d` is unused and may be omitted. A line held high re-sets its pending bit in the same cycle it is acknowledged, so it is presented again after the IDLE cycle.

## Test plan
- Reset: drive `req`=8'hFF and `mask`=8'hFF during `rst`. Required: `irq_valid`=0, `irq_id`=0 and `pending`=0 while `rst`=1. After release, `pending`=8'hFF one edge later and `irq_valid`=1 with `irq_id`=7 one edge after that.
- Priority drain: pulse `req`=8'b0010_0100 for one cycle with `mask`=8'hFF and `ack` held 1. Required: `irq_id` sequence 5 then 2, each valid for 1 cycle and separated by 1 idle cycle. Final `pending`=0.
- Masking: pulse `req[6]`; `mask`=8'hBF. Required: `pending`=8'h40 and `irq_valid` stays 0. Set `mask`=8'hFF; `irq_valid`=1 with `irq_id`=6 one edge later.
- Hold under change: while presenting `irq_id`=3 with `ack`=0, pulse `req[7]` and clear `mask[3]`. Required: `irq_id` stays 3 until `ack`; the next presentation is `irq_id`=7.
- Set/clear collision, edge mode: with id 4 presented, assert `ack` in the same cycle as a new rising edge on `req[4]`. Required: `pending[4]` remains 1 and id 4 is presented again after one idle cycle.
- Level mode (`IRQ_EDGE_DETECT_EN` undefined): hold `req[0]`=1 with `ack` tied 1. Required: `irq_valid` toggles 1,0,1,0… with `irq_id`=0 each time `irq_valid`=1. Drop `req[0]`; after the final ack, `pending`=0 and `irq_valid` stays 0.
